// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory-port arbiter slice.
package mem_arb_pkg;

  localparam int unsigned DEF_AW = 32;
  localparam int unsigned DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the IFU, LSU and memory-wrapper handshakes plus the owner flag.
interface mem_arbiter_if #(
  parameter int unsigned AW = mem_arb_pkg::DEF_AW,
  parameter int unsigned DW = mem_arb_pkg::DEF_DW
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [AW-1:0]     ifu_addr;
  logic              ifu_resp_valid;
  logic [DW-1:0]     ifu_resp_data;
  logic              ifu_resp_ready;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [AW-1:0]     lsu_addr;
  logic              lsu_wen;
  logic [DW-1:0]     lsu_wdata;
  logic [DW/8-1:0]   lsu_wmask;
  logic              lsu_resp_valid;
  logic [DW-1:0]     lsu_resp_data;
  logic              lsu_resp_ready;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [AW-1:0]     mem_addr;
  logic              mem_wen;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_wmask;
  logic              mem_resp_valid;
  logic [DW-1:0]     mem_resp_data;
  logic              mem_resp_ready;

  logic              owner;

  modport slave (
    input  ifu_req_valid, ifu_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    output owner
  );

  modport master (
    output ifu_req_valid, ifu_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask, lsu_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
    input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    input  owner
  );
endinterface

// File: rtl/mem_arb_pick.sv
// LSU-priority pick with a streak counter that forces an IFU win after
// MAX_STREAK consecutive LSU wins while the IFU was waiting.
module mem_arb_pick #(
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ifu_valid,
  input  logic lsu_valid,
  output logic grant_ifu,
  output logic grant_lsu
);
  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  logic [SW-1:0] streak;
  logic          force_ifu;

  always_comb begin
    force_ifu = (streak == STREAK_MAX);
    grant_ifu = en && ifu_valid && (!lsu_valid || force_ifu);
    grant_lsu = en && lsu_valid && !(ifu_valid && force_ifu);
  end

  // Any pick cycle without a waiting IFU, or an IFU win, restarts the count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (en) begin
      if (grant_ifu || !ifu_valid) begin
        streak <= '0;
      end else if (grant_lsu && (streak != STREAK_MAX)) begin
        streak <= streak + 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU and LSU: one transaction in
// flight, request fields and response data held in registers.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);
  state_t          state, state_nxt;
  logic            pick_en, grant_ifu, grant_lsu, owner_rdy;
  logic [AW-1:0]   addr_q;
  logic            wen_q, owner_q;
  logic [DW-1:0]   wdata_q, rdata_q;
  logic [DW/8-1:0] wmask_q;

  // Picking is suppressed while reset is held so no ready is raised then.
  assign pick_en = (state == IDLE) && rst;

  mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .clk       (clk),
    .rst       (rst),
    .en        (pick_en),
    .ifu_valid (bus.ifu_req_valid),
    .lsu_valid (bus.lsu_req_valid),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    owner_rdy = (owner_q == OWN_LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;
    case (state)
      IDLE:    if (grant_ifu || grant_lsu) state_nxt = ISSUE;
      ISSUE:   if (bus.mem_req_ready)      state_nxt = WAIT;
      WAIT:    if (bus.mem_resp_valid)     state_nxt = RESP;
      RESP:    if (owner_rdy)              state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      owner_q <= OWN_IFU;
      rdata_q <= '0;
    end else begin
      if (grant_ifu) begin
        addr_q  <= bus.ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
        owner_q <= OWN_IFU;
      end else if (grant_lsu) begin
        addr_q  <= bus.lsu_addr;
        wen_q   <= bus.lsu_wen;
        wdata_q <= bus.lsu_wdata;
        wmask_q <= bus.lsu_wmask;
        owner_q <= OWN_LSU;
      end
      if ((state == WAIT) && bus.mem_resp_valid) rdata_q <= bus.mem_resp_data;
    end
  end

  assign bus.ifu_req_ready  = grant_ifu;
  assign bus.lsu_req_ready  = grant_lsu;
  assign bus.mem_req_valid  = (state == ISSUE);
  assign bus.mem_resp_ready = (state == WAIT);
  assign bus.ifu_resp_valid = (state == RESP) && (owner_q == OWN_IFU);
  assign bus.lsu_resp_valid = (state == RESP) && (owner_q == OWN_LSU);
  assign bus.ifu_resp_data  = rdata_q;
  assign bus.lsu_resp_data  = rdata_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  assign bus.owner          = owner_q;
endmodule
